// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state, winner and board constants for the pong blocks
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;

    localparam int DEF_BOARD_WIDTH   = 40;
    localparam int DEF_BOARD_HEIGHT  = 30;
    localparam int DEF_PADDLE_HEIGHT = 6;
    localparam int DEF_TICK_DIV      = 1250000;
    localparam int DEF_COORD_W       = 6;

endpackage

// File: rtl/game_tick_gen.sv
// rtl/game_tick_gen.sv - free-running divider giving a one-cycle pulse every TICK_DIV clocks
module game_tick_gen #(
    parameter int TICK_DIV = 1250000
) (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // o_tick is high during the cycle in which the count has just wrapped to 0
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else if (cnt == CNT_W'(TICK_DIV - 1)) begin
            cnt    <= '0;
            o_tick <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match controller: ball motion, collisions, scoring, serve and match FSM
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BOARD_WIDTH   = DEF_BOARD_WIDTH,
    parameter int BOARD_HEIGHT  = DEF_BOARD_HEIGHT,
    parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int SERVE_TICKS   = 10,
    parameter int WIN_SCORE     = 9,
    parameter int SCORE_W       = 4,
    parameter int COORD_W       = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_paddle_y1,
    input  logic [COORD_W-1:0] i_paddle_y2,
    input  logic [COORD_W-1:0] i_col_div,
    input  logic [COORD_W-1:0] i_row_div,
    output logic               o_draw_ball,
    output logic [COORD_W-1:0] o_ball_x,
    output logic [COORD_W-1:0] o_ball_y,
    output logic [SCORE_W-1:0] o_score1,
    output logic [SCORE_W-1:0] o_score2,
    output logic [2:0]         o_state,
    output logic [1:0]         o_winner,
    output logic               o_game_tick
);

    localparam int SC_W = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;

    localparam logic [COORD_W-1:0] CX      = COORD_W'(BOARD_WIDTH / 2);
    localparam logic [COORD_W-1:0] CY      = COORD_W'(BOARD_HEIGHT / 2);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(BOARD_HEIGHT - 1);
    localparam logic [COORD_W-1:0] X_LEFT  = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_RIGHT = COORD_W'(BOARD_WIDTH - 2);

    state_t             state, state_nx;
    logic [COORD_W-1:0] ball_x, ball_y, x_nx, y_nx;
    logic               dx_neg, dy_neg, dx_neg_nx, dy_neg_nx;
    logic [SCORE_W-1:0] score1, score2, s1_nx, s2_nx;
    logic [1:0]         winner, winner_nx;
    logic [SC_W-1:0]    serve_cnt, cnt_nx;
    logic               scorer_p2, scorer_p2_nx;
    logic               tick;
    logic               hit1, hit2;

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    // one extra bit so paddle top + height never wraps near the bottom of the range
    always_comb begin
        hit1 = ({1'b0, ball_y} >= {1'b0, i_paddle_y1}) &&
               ({1'b0, ball_y} <  ({1'b0, i_paddle_y1} + (COORD_W+1)'(PADDLE_HEIGHT)));
        hit2 = ({1'b0, ball_y} >= {1'b0, i_paddle_y2}) &&
               ({1'b0, ball_y} <  ({1'b0, i_paddle_y2} + (COORD_W+1)'(PADDLE_HEIGHT)));
    end

    always_comb begin
        state_nx     = state;
        x_nx         = ball_x;
        y_nx         = ball_y;
        dx_neg_nx    = dx_neg;
        dy_neg_nx    = dy_neg;
        s1_nx        = score1;
        s2_nx        = score2;
        winner_nx    = winner;
        cnt_nx       = serve_cnt;
        scorer_p2_nx = scorer_p2;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nx  = ST_SERVE;
                    x_nx      = CX;
                    y_nx      = CY;
                    cnt_nx    = '0;
                    dx_neg_nx = 1'b0;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    cnt_nx = serve_cnt + 1'b1;
                    if (cnt_nx == SC_W'(SERVE_TICKS)) begin
                        state_nx = ST_RUNNING;
                    end
                end
            end
            ST_RUNNING: begin
                if (tick) begin
                    if ((ball_y == '0) && dy_neg) begin
                        dy_neg_nx = 1'b0;
                        y_nx      = ball_y + 1'b1;
                    end else if ((ball_y == Y_MAX) && !dy_neg) begin
                        dy_neg_nx = 1'b1;
                        y_nx      = ball_y - 1'b1;
                    end else begin
                        y_nx = dy_neg ? ball_y - 1'b1 : ball_y + 1'b1;
                    end
                    // paddle test uses the row before this tick's vertical move
                    if ((ball_x == X_LEFT) && dx_neg) begin
                        if (hit1) begin
                            dx_neg_nx = 1'b0;
                            x_nx      = X_LEFT + 1'b1;
                        end else begin
                            x_nx         = '0;
                            state_nx     = ST_POINT;
                            scorer_p2_nx = 1'b1;
                        end
                    end else if ((ball_x == X_RIGHT) && !dx_neg) begin
                        if (hit2) begin
                            dx_neg_nx = 1'b1;
                            x_nx      = X_RIGHT - 1'b1;
                        end else begin
                            x_nx         = X_RIGHT + 1'b1;
                            state_nx     = ST_POINT;
                            scorer_p2_nx = 1'b0;
                        end
                    end else begin
                        x_nx = dx_neg ? ball_x - 1'b1 : ball_x + 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (scorer_p2) begin
                    s2_nx = score2 + 1'b1;
                end else begin
                    s1_nx = score1 + 1'b1;
                end
                if ((scorer_p2 ? s2_nx : s1_nx) == SCORE_W'(WIN_SCORE)) begin
                    winner_nx = scorer_p2 ? WINNER_P2 : WINNER_P1;
                    state_nx  = ST_GAME_OVER;
                end else begin
                    // next serve heads toward whoever conceded
                    state_nx  = ST_SERVE;
                    x_nx      = CX;
                    y_nx      = CY;
                    cnt_nx    = '0;
                    dx_neg_nx = scorer_p2;
                end
            end
            ST_GAME_OVER: begin
                if (i_start) begin
                    s1_nx     = '0;
                    s2_nx     = '0;
                    winner_nx = WINNER_NONE;
                    dx_neg_nx = 1'b0;
                    state_nx  = ST_SERVE;
                    x_nx      = CX;
                    y_nx      = CY;
                    cnt_nx    = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            ball_x      <= CX;
            ball_y      <= CY;
            dx_neg      <= 1'b0;
            dy_neg      <= 1'b0;
            score1      <= '0;
            score2      <= '0;
            winner      <= WINNER_NONE;
            serve_cnt   <= '0;
            scorer_p2   <= 1'b0;
            o_draw_ball <= 1'b0;
        end else begin
            state       <= state_nx;
            ball_x      <= x_nx;
            ball_y      <= y_nx;
            dx_neg      <= dx_neg_nx;
            dy_neg      <= dy_neg_nx;
            score1      <= s1_nx;
            score2      <= s2_nx;
            winner      <= winner_nx;
            serve_cnt   <= cnt_nx;
            scorer_p2   <= scorer_p2_nx;
            o_draw_ball <= (i_col_div == ball_x) && (i_row_div == ball_y) && (state != ST_IDLE);
        end
    end

    assign o_ball_x    = ball_x;
    assign o_ball_y    = ball_y;
    assign o_score1    = score1;
    assign o_score2    = score2;
    assign o_state     = state;
    assign o_winner    = winner;
    assign o_game_tick = tick;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized scoreboard bench for pong_game_ctrl against a behavioural game model
module tb_pong_game_ctrl;

    localparam int BW = 40;
    localparam int BH = 30;
    localparam int PH = 6;
    localparam int TD = 4;
    localparam int STK = 2;
    localparam int WS = 2;
    localparam int SW = 4;
    localparam int CW = 6;
    localparam int N_CYCLES = 9000;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_paddle_y1 = '0;
    logic [CW-1:0] i_paddle_y2 = '0;
    logic [CW-1:0] i_col_div = '0;
    logic [CW-1:0] i_row_div = '0;
    logic          o_draw_ball;
    logic [CW-1:0] o_ball_x, o_ball_y;
    logic [SW-1:0] o_score1, o_score2;
    logic [2:0]    o_state;
    logic [1:0]    o_winner;
    logic          o_game_tick;

    pong_game_ctrl #(
        .BOARD_WIDTH(BW), .BOARD_HEIGHT(BH), .PADDLE_HEIGHT(PH), .TICK_DIV(TD),
        .SERVE_TICKS(STK), .WIN_SCORE(WS), .SCORE_W(SW), .COORD_W(CW)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_paddle_y1(i_paddle_y1), .i_paddle_y2(i_paddle_y2),
        .i_col_div(i_col_div), .i_row_div(i_row_div),
        .o_draw_ball(o_draw_ball), .o_ball_x(o_ball_x), .o_ball_y(o_ball_y),
        .o_score1(o_score1), .o_score2(o_score2), .o_state(o_state),
        .o_winner(o_winner), .o_game_tick(o_game_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int x; int y; int s1; int s2; int win; int tick; int draw;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_points = 0;
    int   n_games  = 0;

    // game model: states as plain ints, directions as signed unit steps
    int m_st, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_win, m_sc, m_scorer, m_tcnt, m_tick, m_draw;

    task automatic model_reset();
        m_st = 0; m_x = BW / 2; m_y = BH / 2; m_dx = 1; m_dy = 1;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_sc = 0; m_scorer = 0;
        m_tcnt = 0; m_tick = 0; m_draw = 0;
    endtask

    task automatic begin_serve(input int dir);
        m_st = 1; m_x = BW / 2; m_y = BH / 2; m_sc = 0; m_dx = dir;
    endtask

    task automatic model_step(input bit start, input int py1, input int py2, input int col, input int row);
        int  nx, ny, ndy, pts;
        bool_check: begin end
        m_draw = (col == m_x && row == m_y && m_st != 0) ? 1 : 0;
        case (m_st)
            0: if (start) begin_serve(1);
            1: if (m_tick != 0) begin
                m_sc++;
                if (m_sc == STK) m_st = 2;
            end
            2: if (m_tick != 0) begin
                ndy = m_dy;
                if ((m_y == 0 && m_dy < 0) || (m_y == BH - 1 && m_dy > 0)) begin
                    ndy = -m_dy;
                    ny  = m_y - m_dy;
                end else begin
                    ny = m_y + m_dy;
                end
                if (m_x == 1 && m_dx < 0) begin
                    if (py1 <= m_y && m_y < py1 + PH) begin m_dx = 1; nx = 2; end
                    else begin nx = 0; m_st = 3; m_scorer = 2; end
                end else if (m_x == BW - 2 && m_dx > 0) begin
                    if (py2 <= m_y && m_y < py2 + PH) begin m_dx = -1; nx = BW - 3; end
                    else begin nx = BW - 1; m_st = 3; m_scorer = 1; end
                end else begin
                    nx = m_x + m_dx;
                end
                m_x = nx; m_y = ny; m_dy = ndy;
            end
            3: begin
                n_points++;
                if (m_scorer == 2) begin m_s2++; pts = m_s2; end
                else begin m_s1++; pts = m_s1; end
                if (pts == WS) begin m_win = m_scorer; m_st = 4; n_games++; end
                else begin_serve(m_scorer == 2 ? -1 : 1);
            end
            4: if (start) begin
                m_s1 = 0; m_s2 = 0; m_win = 0;
                begin_serve(1);
            end
            default: m_st = 0;
        endcase
        m_tick = (m_tcnt == TD - 1) ? 1 : 0;
        m_tcnt = (m_tcnt == TD - 1) ? 0 : m_tcnt + 1;
    endtask

    // called at a falling edge: drive inputs, advance the model, queue what the DUT must show after the rise
    task automatic step(input bit start);
        int  py1, py2, col, row;
        exp_t e;
        py1 = ($urandom_range(0, 3) != 0) ? m_y - (int'($urandom_range(0, PH + 1)) - 1)
                                          : int'($urandom_range(0, BH - PH));
        py2 = ($urandom_range(0, 3) != 0) ? m_y - (int'($urandom_range(0, PH + 1)) - 1)
                                          : int'($urandom_range(0, BH - PH));
        if (py1 < 0) py1 = 0;
        if (py2 < 0) py2 = 0;
        if ($urandom_range(0, 1) == 1) begin
            col = m_x; row = m_y;
        end else begin
            col = m_x + int'($urandom_range(0, 2)) - 1;
            row = m_y + int'($urandom_range(0, 2)) - 1;
            if (col < 0) col = 0;
            if (row < 0) row = 0;
        end
        i_start = start; i_paddle_y1 = CW'(py1); i_paddle_y2 = CW'(py2);
        i_col_div = CW'(col); i_row_div = CW'(row);
        model_step(start, py1, py2, col, row);
        e.st = m_st; e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2;
        e.win = m_win; e.tick = m_tick; e.draw = m_draw;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string name);
        n_tests++;
        if (o_state !== 3'd0 || o_ball_x !== CW'(BW / 2) || o_ball_y !== CW'(BH / 2) ||
            o_score1 !== '0 || o_score2 !== '0 || o_winner !== 2'd0 ||
            o_draw_ball !== 1'b0 || o_game_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ball=(%0d,%0d) s=%0d/%0d win=%0d draw=%0d tick=%0d, want st=0 ball=(%0d,%0d) s=0/0 win=0 draw=0 tick=0",
                     name, o_state, o_ball_x, o_ball_y, o_score1, o_score2, o_winner,
                     o_draw_ball, o_game_tick, BW / 2, BH / 2);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (int'(o_state) != e.st || int'(o_ball_x) != e.x || int'(o_ball_y) != e.y ||
                int'(o_score1) != e.s1 || int'(o_score2) != e.s2 || int'(o_winner) != e.win ||
                int'(o_game_tick) != e.tick || int'(o_draw_ball) != e.draw) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: got st=%0d ball=(%0d,%0d) s=%0d/%0d win=%0d tick=%0d draw=%0d, want st=%0d ball=(%0d,%0d) s=%0d/%0d win=%0d tick=%0d draw=%0d",
                         $time, o_state, o_ball_x, o_ball_y, o_score1, o_score2, o_winner,
                         o_game_tick, o_draw_ball, e.st, e.x, e.y, e.s1, e.s2, e.win, e.tick, e.draw);
            end
        end
    end

    initial begin
        bit did_rst;
        did_rst = 1'b0;
        model_reset();
        #2 i_rst_n = 1'b0;
        #1 check_reset_values("reset_initial");
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            step(1'b0);
        end
        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk);
            step($urandom_range(0, 15) == 0);
            if (!did_rst && i > N_CYCLES / 2 && m_st == 2) begin
                did_rst = 1'b1;
                @(posedge clk);
                #3 i_rst_n = 1'b0;
                #1 check_reset_values("reset_midrun");
                model_reset();
                @(negedge clk);
                @(negedge clk);
                i_rst_n = 1'b1;
                for (int k = 0; k < 15; k++) begin
                    if (k > 0) @(negedge clk);
                    step(1'b0);
                end
            end
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        n_tests++;
        if (!did_rst || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL coverage: midrun_reset=%0d pending=%0d, want midrun_reset=1 pending=0",
                     did_rst, exp_q.size());
        end
        n_tests++;
        if (n_points < 2 || n_games < 1) begin
            n_fail++;
            $display("FAIL coverage: points=%0d games=%0d, want points>=2 games>=1", n_points, n_games);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
